// File: rtl/video_mnist_seg_pkg.sv
// Shared constants for the MNIST segmentation sideband stream (vote producer and colouring stage).
// Holds the class/voter geometry, the derived field widths and the class-field slice convention.
// Both ends of the stream take their widths from here, so the two sides cannot disagree.
package video_mnist_seg_pkg;

  localparam int TUSER_WIDTH   = 1;
  localparam int TDATA_WIDTH   = 32;
  localparam int NUM_CLASS     = 10;
  localparam int CLASS_BITS    = 7;
  localparam int DETECT_BITS   = 7;

  // The index must reach NUM_CLASS-1 and the count must hold CLASS_BITS.
  // These are shared with the colouring block, so they are fixed values
  // rather than minimal widths.
  localparam int TNUMBER_WIDTH = 4;
  localparam int TCOUNT_WIDTH  = 4;

  // Class k occupies tclass[k*bits +: bits].
  function automatic int class_lsb(input int k, input int bits);
    return k * bits;
  endfunction

endpackage

// File: rtl/video_mnist_seg_vote_if.sv
// Stream interfaces around the vote producer.
// s_if: raw pixel + voter bits from the LUT network; m_if: pixel + vote result to the colouring stage.
// Both use valid/ready; modports master (source) and slave (sink).
interface video_mnist_seg_vote_s_if #(
  parameter int TUSER_WIDTH = video_mnist_seg_pkg::TUSER_WIDTH,
  parameter int TDATA_WIDTH = video_mnist_seg_pkg::TDATA_WIDTH,
  parameter int NUM_CLASS   = video_mnist_seg_pkg::NUM_CLASS,
  parameter int CLASS_BITS  = video_mnist_seg_pkg::CLASS_BITS,
  parameter int DETECT_BITS = video_mnist_seg_pkg::DETECT_BITS
);
  logic [TUSER_WIDTH-1:0]          tuser;
  logic                            tlast;
  logic [TDATA_WIDTH-1:0]          tdata;
  logic                            tbinary;
  logic [NUM_CLASS*CLASS_BITS-1:0] tclass;
  logic [DETECT_BITS-1:0]          tdetect;
  logic                            tvalid;
  logic                            tready;

  modport master (output tuser, tlast, tdata, tbinary, tclass, tdetect, tvalid, input tready);
  modport slave  (input tuser, tlast, tdata, tbinary, tclass, tdetect, tvalid, output tready);
endinterface

interface video_mnist_seg_vote_m_if #(
  parameter int TUSER_WIDTH   = video_mnist_seg_pkg::TUSER_WIDTH,
  parameter int TDATA_WIDTH   = video_mnist_seg_pkg::TDATA_WIDTH,
  parameter int TNUMBER_WIDTH = video_mnist_seg_pkg::TNUMBER_WIDTH,
  parameter int TCOUNT_WIDTH  = video_mnist_seg_pkg::TCOUNT_WIDTH
);
  logic [TUSER_WIDTH-1:0]   tuser;
  logic                     tlast;
  logic [TNUMBER_WIDTH-1:0] tnumber;
  logic [TCOUNT_WIDTH-1:0]  tcount;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic                     tbinary;
  logic                     tdetection;
  logic                     tvalid;
  logic                     tready;

  modport master (output tuser, tlast, tnumber, tcount, tdata, tbinary, tdetection, tvalid,
                  input tready);
  modport slave  (input tuser, tlast, tnumber, tcount, tdata, tbinary, tdetection, tvalid,
                  output tready);
endinterface

// File: rtl/video_mnist_seg_argmax.sv
// Combinational argmax over NUM packed CW-bit counts: returns {idx, max_cnt}.
// Ties resolve to the lowest index; all-zero counts give idx 0, max 0.
// Ports: counts (class k at [k*CW +: CW]) in, idx / max_cnt out.
module video_mnist_seg_argmax #(
  parameter int NUM = 10,
  parameter int CW  = 4,
  parameter int IW  = 4
) (
  input  logic [NUM*CW-1:0] counts,
  output logic [IW-1:0]     idx,
  output logic [CW-1:0]     max_cnt
);

  // Scan upward with a strict compare so an equal later count never displaces
  // an earlier winner.
  always_comb begin
    idx     = '0;
    max_cnt = counts[CW-1:0];
    for (int k = 1; k < NUM; k++) begin
      if (counts[k*CW +: CW] > max_cnt) begin
        max_cnt = counts[k*CW +: CW];
        idx     = IW'(k);
      end
    end
  end

endmodule

// File: rtl/video_mnist_seg_vote.sv
// Vote producer: popcount per class (S1), argmax + detection majority (S2), output register (S3).
// Latency 3 cycles, 1 beat/cycle; single global enable cke = !m.tvalid || m.tready stalls all stages.
// Ports: aclk, aresetn (sync, active-low), s_axi4s (slave stream in), m_axi4s (master stream out).
module video_mnist_seg_vote #(
  parameter int TUSER_WIDTH   = video_mnist_seg_pkg::TUSER_WIDTH,
  parameter int TDATA_WIDTH   = video_mnist_seg_pkg::TDATA_WIDTH,
  parameter int NUM_CLASS     = video_mnist_seg_pkg::NUM_CLASS,
  parameter int CLASS_BITS    = video_mnist_seg_pkg::CLASS_BITS,
  parameter int DETECT_BITS   = video_mnist_seg_pkg::DETECT_BITS,
  parameter int TNUMBER_WIDTH = video_mnist_seg_pkg::TNUMBER_WIDTH,
  parameter int TCOUNT_WIDTH  = video_mnist_seg_pkg::TCOUNT_WIDTH
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  video_mnist_seg_vote_s_if.slave  s_axi4s,
  video_mnist_seg_vote_m_if.master m_axi4s
);
  import video_mnist_seg_pkg::*;

  localparam int DCNT_WIDTH = $clog2(DETECT_BITS + 1);

  // Configuration checks: index must reach NUM_CLASS-1, count must hold CLASS_BITS.
  if ((1 << TNUMBER_WIDTH) < NUM_CLASS) begin : g_bad_tnumber_width
    $error("TNUMBER_WIDTH too small for NUM_CLASS");
  end
  if ((1 << TCOUNT_WIDTH) <= CLASS_BITS) begin : g_bad_tcount_width
    $error("TCOUNT_WIDTH too small to hold CLASS_BITS");
  end

  logic cke;
  logic vld1, vld2, vld3;

  // One enable for the whole pipe: advance whenever the output slot is empty
  // or being taken this cycle.
  assign cke            = !vld3 || m_axi4s.tready;
  assign s_axi4s.tready = cke && aresetn;

  // ---------------- S1: popcounts ----------------
  logic [NUM_CLASS*TCOUNT_WIDTH-1:0] cnt_d, cnt1;
  logic [DCNT_WIDTH-1:0]             det_d, det1;
  logic [TUSER_WIDTH-1:0]            user1, user2, user3;
  logic                              last1, last2, last3;
  logic [TDATA_WIDTH-1:0]            data1, data2, data3;
  logic                              bin1, bin2, bin3;

  always_comb begin
    cnt_d = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      for (int b = 0; b < CLASS_BITS; b++) begin
        cnt_d[k*TCOUNT_WIDTH +: TCOUNT_WIDTH] = cnt_d[k*TCOUNT_WIDTH +: TCOUNT_WIDTH]
          + TCOUNT_WIDTH'(s_axi4s.tclass[class_lsb(k, CLASS_BITS) + b]);
      end
    end
  end

  always_comb begin
    det_d = '0;
    for (int b = 0; b < DETECT_BITS; b++) begin
      det_d = det_d + DCNT_WIDTH'(s_axi4s.tdetect[b]);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld1  <= 1'b0;
      cnt1  <= '0;
      det1  <= '0;
      user1 <= '0;
      last1 <= 1'b0;
      data1 <= '0;
      bin1  <= 1'b0;
    end else if (cke) begin
      vld1  <= s_axi4s.tvalid;
      cnt1  <= cnt_d;
      det1  <= det_d;
      user1 <= s_axi4s.tuser;
      last1 <= s_axi4s.tlast;
      data1 <= s_axi4s.tdata;
      bin1  <= s_axi4s.tbinary;
    end
  end

  // ---------------- S2: argmax + detection majority ----------------
  logic [TNUMBER_WIDTH-1:0] num_d, num2, num3;
  logic [TCOUNT_WIDTH-1:0]  max_d, cnt2, cnt3;
  logic                     detn2, detn3;

  video_mnist_seg_argmax #(
    .NUM (NUM_CLASS),
    .CW  (TCOUNT_WIDTH),
    .IW  (TNUMBER_WIDTH)
  ) u_argmax (
    .counts  (cnt1),
    .idx     (num_d),
    .max_cnt (max_d)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld2  <= 1'b0;
      num2  <= '0;
      cnt2  <= '0;
      detn2 <= 1'b0;
      user2 <= '0;
      last2 <= 1'b0;
      data2 <= '0;
      bin2  <= 1'b0;
    end else if (cke) begin
      vld2  <= vld1;
      num2  <= num_d;
      cnt2  <= max_d;
      // Strict majority: more than half of the detection voters.
      detn2 <= (det1 > DCNT_WIDTH'(DETECT_BITS / 2));
      user2 <= user1;
      last2 <= last1;
      data2 <= data1;
      bin2  <= bin1;
    end
  end

  // ---------------- S3: output register ----------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld3  <= 1'b0;
      num3  <= '0;
      cnt3  <= '0;
      detn3 <= 1'b0;
      user3 <= '0;
      last3 <= 1'b0;
      data3 <= '0;
      bin3  <= 1'b0;
    end else if (cke) begin
      vld3  <= vld2;
      num3  <= num2;
      cnt3  <= cnt2;
      detn3 <= detn2;
      user3 <= user2;
      last3 <= last2;
      data3 <= data2;
      bin3  <= bin2;
    end
  end

  assign m_axi4s.tvalid     = vld3;
  assign m_axi4s.tuser      = user3;
  assign m_axi4s.tlast      = last3;
  assign m_axi4s.tnumber    = num3;
  assign m_axi4s.tcount     = cnt3;
  assign m_axi4s.tdata      = data3;
  assign m_axi4s.tbinary    = bin3;
  assign m_axi4s.tdetection = detn3;

endmodule

// File: tb/tb_video_mnist_seg_vote.sv
// Bench for video_mnist_seg_vote: directed vectors plus a reference-modelled random stream.
// Expected beats are queued on acceptance; a negedge monitor pops and compares on each handshake.
// Also covers output stability under backpressure, drain rate and mid-stream reset.
module tb_video_mnist_seg_vote;
  import video_mnist_seg_pkg::*;

  localparam int CW_ALL = NUM_CLASS * CLASS_BITS;

  typedef struct {
    logic [TUSER_WIDTH-1:0]   tuser;
    logic                     tlast;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic                     tbinary;
    logic [TNUMBER_WIDTH-1:0] tnumber;
    logic [TCOUNT_WIDTH-1:0]  tcount;
    logic                     tdetection;
    int                       acc_cyc;
    bit                       chk_lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_pop  = 0;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic rnd_rdy = 1'b0;
  logic rnd_bit = 1'b0;
  logic rdy_man = 1'b1;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  video_mnist_seg_vote_s_if s_if ();
  video_mnist_seg_vote_m_if m_if ();

  assign m_if.tready = rnd_rdy ? rnd_bit : rdy_man;

  video_mnist_seg_vote u_dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axi4s (s_if),
    .m_axi4s (m_if)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent reference: popcount per class, first maximum wins.
  task automatic model(input logic [CW_ALL-1:0] cls, input logic [DETECT_BITS-1:0] det,
                       output int num, output int cnt, output bit dt);
    num = 0;
    cnt = -1;
    for (int k = 0; k < NUM_CLASS; k++) begin
      logic [CLASS_BITS-1:0] f;
      f = cls[k*CLASS_BITS +: CLASS_BITS];
      if ($countones(f) > cnt) begin
        cnt = $countones(f);
        num = k;
      end
    end
    dt = ($countones(det) > DETECT_BITS / 2);
  endtask

  task automatic send(input logic [TUSER_WIDTH-1:0] u, input logic l, input logic [TDATA_WIDTH-1:0] d,
                      input logic b, input logic [CW_ALL-1:0] cls, input logic [DETECT_BITS-1:0] det,
                      input int en, input int ec, input bit edet, input bit lat);
    exp_t e;
    bit   ok;
    s_if.tuser   = u;
    s_if.tlast   = l;
    s_if.tdata   = d;
    s_if.tbinary = b;
    s_if.tclass  = cls;
    s_if.tdetect = det;
    s_if.tvalid  = 1'b1;
    e.tuser      = u;
    e.tlast      = l;
    e.tdata      = d;
    e.tbinary    = b;
    e.tnumber    = TNUMBER_WIDTH'(en);
    e.tcount     = TCOUNT_WIDTH'(ec);
    e.tdetection = edet;
    e.chk_lat    = lat;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge aclk);
      if (s_if.tready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", 64'(ok), 64'(1));
    if (ok) begin
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 300; t++) begin
      if (sb.size() == 0) break;
      @(posedge aclk);
    end
    #1;
    check(name, 64'(sb.size()), 64'(0));
  endtask

  // Monitor: scoreboard pop on handshake, stability while stalled.
  exp_t        me;
  logic        hold_pending = 1'b0;
  logic [63:0] snap;
  logic [63:0] cur;

  always @(negedge aclk) begin
    cur = 64'({m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tnumber, m_if.tcount,
               m_if.tdata, m_if.tbinary, m_if.tdetection});
    if (!aresetn) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) check("stall_stable", cur, snap);
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'(m_if.tdata), 64'(0) ^ 64'(m_if.tdata) ^ 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          me = sb.pop_front();
          check("tnumber", 64'(m_if.tnumber), 64'(me.tnumber));
          check("tcount", 64'(m_if.tcount), 64'(me.tcount));
          check("tdetection", 64'(m_if.tdetection), 64'(me.tdetection));
          check("sideband", 64'({m_if.tuser, m_if.tlast, m_if.tbinary, m_if.tdata}),
                64'({me.tuser, me.tlast, me.tbinary, me.tdata}));
          if (me.chk_lat) check("latency", 64'(cyc - me.acc_cyc), 64'(3));
          n_pop++;
        end
        hold_pending = 1'b0;
      end else if (m_if.tvalid === 1'b1) begin
        hold_pending = 1'b1;
        snap = cur;
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW_ALL-1:0] c;
    int num, cnt, p0;
    bit dt;

    s_if.tvalid  = 1'b0;
    s_if.tuser   = '0;
    s_if.tlast   = 1'b0;
    s_if.tdata   = '0;
    s_if.tbinary = 1'b0;
    s_if.tclass  = '0;
    s_if.tdetect = '0;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_tvalid", 64'(m_if.tvalid), 64'(0));
    check("rst_tuser", 64'(m_if.tuser), 64'(0));
    check("rst_tlast", 64'(m_if.tlast), 64'(0));
    check("rst_tnumber", 64'(m_if.tnumber), 64'(0));
    check("rst_tcount", 64'(m_if.tcount), 64'(0));
    check("rst_tdata", 64'(m_if.tdata), 64'(0));
    check("rst_tbinary", 64'(m_if.tbinary), 64'(0));
    check("rst_tdetection", 64'(m_if.tdetection), 64'(0));
    check("rst_s_tready", 64'(s_if.tready), 64'(0));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Class 3 unanimous, detect 4 of 7
    c = '0;
    c[3*CLASS_BITS +: CLASS_BITS] = 7'b1111111;
    send(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, c, 7'b0001111, 3, 7, 1'b1, 1'b1);
    // Tie between classes 2 and 5 at 5 votes, detect 3 of 7
    c = '0;
    c[0*CLASS_BITS +: CLASS_BITS] = 7'b0001111;
    c[2*CLASS_BITS +: CLASS_BITS] = 7'b0011111;
    c[5*CLASS_BITS +: CLASS_BITS] = 7'b1110011;
    c[7*CLASS_BITS +: CLASS_BITS] = 7'b0000111;
    send(1'b0, 1'b0, 32'h1234_5678, 1'b0, c, 7'b0000111, 2, 5, 1'b0, 1'b1);
    // All voters zero
    send(1'b0, 1'b0, 32'h0000_0001, 1'b1, '0, 7'b0000000, 0, 0, 1'b0, 1'b1);
    // Only highest class voting, one vote
    c = '0;
    c[9*CLASS_BITS] = 1'b1;
    send(1'b0, 1'b1, 32'hA5A5_5A5A, 1'b0, c, 7'b1111111, 9, 1, 1'b1, 1'b1);
    // Tie at the two ends: class 0 and class 9 both full
    c = '0;
    c[0*CLASS_BITS +: CLASS_BITS] = 7'b1111111;
    c[9*CLASS_BITS +: CLASS_BITS] = 7'b1111111;
    send(1'b1, 1'b0, 32'hFFFF_0000, 1'b1, c, 7'b1011000, 0, 7, 1'b0, 1'b1);
    drain("drain_directed");

    // Random 100-beat stream with 50% output ready
    rnd_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      c = CW_ALL'({$urandom(), $urandom(), $urandom()});
      s_if.tdetect = DETECT_BITS'($urandom());
      model(c, s_if.tdetect, num, cnt, dt);
      send(TUSER_WIDTH'(i == 0), (i % 10) == 9, $urandom(), 1'($urandom_range(0, 1)),
           c, s_if.tdetect, num, cnt, dt, 1'b0);
    end
    drain("drain_stream");
    rnd_rdy = 1'b0;
    rdy_man = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // Backpressure: three beats in flight with the output held off
    rdy_man = 1'b0;
    c = '0;
    c[1*CLASS_BITS +: CLASS_BITS] = 7'b0000011;
    send(1'b0, 1'b0, 32'h0000_00A1, 1'b0, c, 7'b0000000, 1, 2, 1'b0, 1'b0);
    c = '0;
    c[4*CLASS_BITS +: CLASS_BITS] = 7'b0111111;
    send(1'b0, 1'b0, 32'h0000_00A2, 1'b1, c, 7'b1111000, 4, 6, 1'b1, 1'b0);
    c = '0;
    c[8*CLASS_BITS +: CLASS_BITS] = 7'b0100000;
    send(1'b0, 1'b1, 32'h0000_00A3, 1'b0, c, 7'b0011100, 8, 1, 1'b0, 1'b0);
    @(negedge aclk);
    check("stall_s_tready", 64'(s_if.tready), 64'(0));
    check("stall_m_tvalid", 64'(m_if.tvalid), 64'(1));
    repeat (3) @(posedge aclk);
    #1;
    p0 = n_pop;
    rdy_man = 1'b1;
    repeat (3) @(negedge aclk);
    @(posedge aclk);
    #1;
    check("drain_rate", 64'(n_pop - p0), 64'(3));
    @(negedge aclk);
    check("drain_empty", 64'(m_if.tvalid), 64'(0));
    @(posedge aclk);
    #1;

    // Mid-stream reset with two beats in flight
    c = '0;
    c[6*CLASS_BITS +: CLASS_BITS] = 7'b1111111;
    send(1'b0, 1'b0, 32'hBAD0_0001, 1'b1, c, 7'b1111111, 6, 7, 1'b1, 1'b0);
    send(1'b0, 1'b0, 32'hBAD0_0002, 1'b1, c, 7'b1111111, 6, 7, 1'b1, 1'b0);
    aresetn = 1'b0;
    sb.delete();
    @(negedge aclk);
    check("rst_mid_s_tready", 64'(s_if.tready), 64'(0));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_mid_tvalid", 64'(m_if.tvalid), 64'(0));
    check("rst_mid_tdata", 64'(m_if.tdata), 64'(0));
    check("rst_mid_tnumber", 64'(m_if.tnumber), 64'(0));
    @(posedge aclk);
    #1;
    c = '0;
    c[5*CLASS_BITS +: CLASS_BITS] = 7'b0001011;
    send(1'b1, 1'b1, 32'h600D_0001, 1'b0, c, 7'b0110110, 5, 3, 1'b1, 1'b1);
    drain("drain_after_reset");
    repeat (6) @(posedge aclk);
    #1;
    check("final_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
